// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - IF/MEM arbiter sequencing SETUP/STROBE/LATCH cycles on a single-port SRAM (optional ARB_ROUND_ROBIN_EN)
module sram_bus_arbiter #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 18,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              stall_req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_LATCH} state_t;

    localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt_mem_q, gnt_mem_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              pick_mem;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;  // 1 = MEM was granted last
`endif

    // Arbitration choice: who gets the bus if a grant happens this cycle
    always_comb begin
        pick_mem = mem_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (mem_req && if_req) begin
            pick_mem = ~last_grant_q;
        end
`endif
    end

    // Next-state and registered-output logic for the SRAM cycle sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_mem_d   = gnt_mem_q;
        we_d        = we_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    gnt_mem_d = pick_mem;
                    we_d      = pick_mem & mem_we;
                    addr_d    = pick_mem ? mem_addr : if_addr;
                    if (pick_mem && mem_we) begin
                        dq_o_d = mem_wdata;
                    end
                    ce_n_d    = 1'b0;
                    dq_oe_d   = pick_mem & mem_we;
                    state_d   = ST_SETUP;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = pick_mem;
`endif
                end
            end
            ST_SETUP: begin
                oe_n_d  = we_q;
                we_n_d  = ~we_q;
                cnt_d   = CNT_INIT;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (gnt_mem_q) begin
                        mem_ack_d = 1'b1;
                    end else begin
                        if_ack_d = 1'b1;
                    end
                    // Data is sampled while OE_n is still low on this edge
                    if (!we_q) begin
                        if (gnt_mem_q) begin
                            mem_rdata_d = sram_dq_i;
                        end else begin
                            if_rdata_d = sram_dq_i;
                        end
                    end
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the strobes immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            gnt_mem_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_mem_q   <= gnt_mem_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_ack     = if_ack_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ack    = mem_ack_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign stall_req  = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - self-checking bench for sram_bus_arbiter
module tb_sram_bus_arbiter;
    localparam int DW = 16;
    localparam int AW = 18;
    localparam int S  = 2;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_req;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    sram_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STROBE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_req(stall_req),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Board SRAM: reads while CE_n/OE_n low, writes on edges while WE_n low
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : '0;
    always @(posedge clk) begin
        if (rst && !sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_o;
    end

    // Transaction-level model: m_d counts cycles since the grant edge.
    // d=1 setup, d=2..S+1 strobe, d=S+2 ack, d=S+3 turnaround idle.
    bit            m_active;
    int            m_d;
    bit            m_gmem;
    bit            m_wr;
    bit            m_last_mem;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_if_rdata;
    logic [DW-1:0] m_mem_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_d = 0; m_last_mem = 0;
            m_if_rdata = '0; m_mem_rdata = '0;
        end else if (m_active) begin
            m_d++;
            if (m_d == S + 2 && !m_wr) begin
                if (m_gmem) m_mem_rdata = sram_mem[m_addr];
                else        m_if_rdata  = sram_mem[m_addr];
            end
            if (m_d == S + 3) m_active = 0;
        end else if (if_req || mem_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_gmem = mem_req && !(if_req && m_last_mem);
`else
            m_gmem = mem_req;
`endif
            m_last_mem = m_gmem;
            m_wr     = m_gmem && mem_we;
            m_addr   = m_gmem ? mem_addr : if_addr;
            m_wdata  = mem_wdata;
            m_active = 1;
            m_d      = 1;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        bit in_cyc, strobe, ackc, e_if_ack, e_mem_ack;
        in_cyc    = m_active && m_d >= 1 && m_d <= S + 1;
        strobe    = m_active && m_d >= 2 && m_d <= S + 1;
        ackc      = m_active && m_d == S + 2;
        e_if_ack  = ackc && !m_gmem;
        e_mem_ack = ackc && m_gmem;
        chk("ce_n", sram_ce_n, !in_cyc);
        chk("oe_n", sram_oe_n, !(strobe && !m_wr));
        chk("we_n", sram_we_n, !(strobe && m_wr));
        chk("dq_oe", sram_dq_oe, in_cyc && m_wr);
        chk("if_ack", if_ack, e_if_ack);
        chk("mem_ack", mem_ack, e_mem_ack);
        chk("stall", stall_req, (if_req && !e_if_ack) || (mem_req && !e_mem_ack));
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("mem_rdata", mem_rdata, m_mem_rdata);
        if (in_cyc || ackc) chk("addr", sram_addr, m_addr);
        if (in_cyc && m_wr) chk("dq_o", sram_dq_o, m_wdata);
    end

    int we_low = 0;
    int oe_hi  = 0;
    int if_acks = 0;
    int mem_acks = 0;
    always @(negedge clk) begin
        if (!sram_we_n) we_low++;
        if (sram_dq_oe) oe_hi++;
        if (if_ack) if_acks++;
        if (mem_ack) mem_acks++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit want_mem, output int at);
        int k;
        at = -1;
        k = 0;
        while (at < 0 && k < 40) begin
            @(negedge clk);
            if (want_mem ? mem_ack : if_ack) at = cyc;
            k++;
        end
        chk(want_mem ? "mem_ack_seen" : "if_ack_seen", at >= 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, a1, a2, a3, k, acks0;
        bit first_mem;
        sram_mem[18'h00010] = 16'h1234;
        sram_mem[18'h00100] = 16'hAAAA;
        sram_mem[18'h00200] = 16'h5555;
        rst = 0; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0;
        mem_addr = '0; mem_wdata = '0;
        repeat (3) step();
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rdata", if_rdata, 0);
        @(negedge clk) rst = 1;
        step();

        // 1: IF read
        we_low = 0;
        if_addr = 18'h00010; if_req = 1; t = cyc;
        wait_ack(0, a1);
        chk("t1_latency", a1 - t, 4);
        chk("t1_rdata", if_rdata, 16'h1234);
        step(); if_req = 0;
        repeat (3) step();
        chk("t1_we_n_low", we_low, 0);
        chk("t1_rdata_held", if_rdata, 16'h1234);

        // 2: MEM write
        we_low = 0; oe_hi = 0; acks0 = mem_acks;
        mem_addr = 18'h3FFFF; mem_wdata = 16'hBEEF; mem_we = 1; mem_req = 1; t = cyc;
        wait_ack(1, a1);
        chk("t2_latency", a1 - t, 4);
        step(); mem_req = 0; mem_we = 0;
        repeat (3) step();
        chk("t2_we_low", we_low, 2);
        chk("t2_dq_oe_cycles", oe_hi, 3);
        chk("t2_sram_data", sram_mem[18'h3FFFF], 16'hBEEF);
        chk("t2_ack_pulses", mem_acks - acks0, 1);

        // 3/4: simultaneous reads; last grant was MEM
`ifdef ARB_ROUND_ROBIN_EN
        first_mem = 0;
`else
        first_mem = 1;
`endif
        if_addr = 18'h00100; mem_addr = 18'h00200; if_req = 1; mem_req = 1; t = cyc;
        wait_ack(first_mem, a1);
        step();
        if (first_mem) mem_req = 0; else if_req = 0;
        wait_ack(!first_mem, a2);
        step(); if_req = 0; mem_req = 0;
        chk("t3_first_latency", a1 - t, 4);
        chk("t3_second_latency", a2 - t, 9);
        chk("t3_if_rdata", if_rdata, 16'hAAAA);
        chk("t3_mem_rdata", mem_rdata, 16'h5555);
        repeat (2) step();

        // 5: reset during the strobe of a write
        acks0 = mem_acks;
        mem_addr = 18'h00300; mem_wdata = 16'h1111; mem_we = 1; mem_req = 1;
        k = 0;
        while (sram_we_n && k < 20) begin @(negedge clk); k++; end
        chk("t5_reached_strobe", sram_we_n, 0);
        #2 rst = 0;
        #1;
        chk("t5_async_we_n", sram_we_n, 1);
        chk("t5_async_ce_n", sram_ce_n, 1);
        chk("t5_async_dq_oe", sram_dq_oe, 0);
        mem_req = 0; mem_we = 0;
        repeat (3) step();
        @(negedge clk) rst = 1;
        step();
        chk("t5_no_ack", mem_acks - acks0, 0);
        if_addr = 18'h00100; if_req = 1; t = cyc;
        wait_ack(0, a1);
        chk("t5_after_latency", a1 - t, 4);
        chk("t5_after_rdata", if_rdata, 16'hAAAA);
        step(); if_req = 0;
        repeat (2) step();

        // 6: MEM held for three reads; IF starves under fixed priority
`ifndef ARB_ROUND_ROBIN_EN
        acks0 = if_acks;
        if_addr = 18'h00010; if_req = 1;
        mem_addr = 18'h3FFFF; mem_we = 0; mem_req = 1;
        wait_ack(1, a1);
        wait_ack(1, a2);
        wait_ack(1, a3);
        chk("t6_space1", a2 - a1, 5);
        chk("t6_space2", a3 - a2, 5);
        chk("t6_if_starved", if_acks - acks0, 0);
        chk("t6_mem_rdata", mem_rdata, 16'hBEEF);
        step(); mem_req = 0;
        wait_ack(0, a1);
        chk("t6_if_after", a1 - a3, 5);
        step(); if_req = 0;
`endif
        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
